// File: rtl/fp16_to_fixed_seq_pkg.sv
// Shared constants, FSM state type and decoded-field bundle for the
// half-precision to fixed-point converter.
package fp16_to_fixed_seq_pkg;

  localparam int FP_EXP_W   = 5;
  localparam int FP_MAN_W   = 10;
  localparam int FP_BIAS    = 15;
  localparam int FP_EXP_MAX = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Everything the sequencer needs from one fp16 word, resolved combinationally.
  typedef struct packed {
    logic                sign;
    logic                hidden;
    logic [FP_MAN_W-1:0] mant;
    logic [3:0]          n;         // alignment shift distance, 0 for specials
    logic                dir_left;  // 1: shift toward integer part
    logic                is_zero;
    logic                is_inf;
    logic                is_nan;
  } fp16_fields_t;

endpackage

// File: rtl/fp16_to_fixed_seq_if.sv
// Handshake and result bundle between the converter and its producer/consumer.
interface fp16_to_fixed_seq_if #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       fp_in;
  logic              out_valid;
  logic              out_ready;
  logic              sign_out;
  logic [INT_W-1:0]  int_out;
  logic [FRAC_W-1:0] frac_out;
  logic              zero_out;
  logic              inf_out;
  logic              nan_out;

  modport master (
    output in_valid, fp_in, out_ready,
    input  in_ready, out_valid, sign_out, int_out, frac_out,
           zero_out, inf_out, nan_out
  );

  modport slave (
    input  in_valid, fp_in, out_ready,
    output in_ready, out_valid, sign_out, int_out, frac_out,
           zero_out, inf_out, nan_out
  );
endinterface

// File: rtl/fp16_to_fixed_seq_field_decode.sv
// Splits an fp16 word into the fields the alignment sequencer loads:
// sign, hidden bit, mantissa, shift distance/direction and class flags.
module fp16_field_decode
  import fp16_to_fixed_seq_pkg::*;
(
  input  logic [15:0]  fp_in,
  output fp16_fields_t fields
);

  logic [FP_EXP_W-1:0] exp_f;
  logic [FP_EXP_W-1:0] ee;

  assign exp_f = fp_in[14:10];

  // Denormals share the exponent of the smallest normal; specials never shift.
  always_comb begin
    fields         = '0;
    fields.sign    = fp_in[15];
    fields.mant    = fp_in[FP_MAN_W-1:0];
    fields.hidden  = (exp_f != '0);
    fields.is_zero = (exp_f == '0) && (fp_in[FP_MAN_W-1:0] == '0);
    fields.is_inf  = (exp_f == FP_EXP_W'(FP_EXP_MAX)) && (fp_in[FP_MAN_W-1:0] == '0);
    fields.is_nan  = (exp_f == FP_EXP_W'(FP_EXP_MAX)) && (fp_in[FP_MAN_W-1:0] != '0);
    ee             = (exp_f == '0) ? FP_EXP_W'(1) : exp_f;
    if (ee > FP_EXP_W'(FP_BIAS)) begin
      fields.dir_left = 1'b1;
      fields.n        = 4'(ee - FP_EXP_W'(FP_BIAS));
    end else begin
      fields.dir_left = 1'b0;
      fields.n        = 4'(FP_EXP_W'(FP_BIAS) - ee);
    end
    if (fields.is_zero || (exp_f == FP_EXP_W'(FP_EXP_MAX))) begin
      fields.n = '0;
    end
  end

endmodule

// File: rtl/fp16_to_fixed_seq.sv
// Serial fp16 -> sign + unsigned INT_W.FRAC_W converter. The significand is
// loaded at the binary point and walked one bit per cycle to its weight.
//
//  state | meaning
//  IDLE  | waiting for a word, in_ready high
//  SHIFT | aligning acc, count cycles remain
//  DONE  | result presented, waiting for out_ready
module fp16_to_fixed_seq
  import fp16_to_fixed_seq_pkg::*;
#(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  fp16_to_fixed_seq_if.slave  bus
);

  localparam int ACC_W = INT_W + FRAC_W;

  state_t           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic             dir_left_q, dir_left_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             inf_q, inf_d;
  logic             nan_q, nan_d;
  fp16_fields_t     fields;
  logic             done;

  fp16_field_decode u_decode (
    .fp_in  (bus.fp_in),
    .fields (fields)
  );

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      dir_left_q <= 1'b0;
      acc_q      <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      inf_q      <= 1'b0;
      nan_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dir_left_q <= dir_left_d;
      acc_q      <= acc_d;
      sign_q     <= sign_d;
      zero_q     <= zero_d;
      inf_q      <= inf_d;
      nan_q      <= nan_d;
    end
  end

  // Next-state and datapath update: load on accept, shift, then hold for the consumer.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dir_left_d = dir_left_q;
    acc_d      = acc_q;
    sign_d     = sign_q;
    zero_d     = zero_q;
    inf_d      = inf_q;
    nan_d      = nan_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d     = fields.sign;
          zero_d     = fields.is_zero;
          inf_d      = fields.is_inf;
          nan_d      = fields.is_nan;
          dir_left_d = fields.dir_left;
          count_d    = fields.n;
          if (fields.is_inf || fields.is_nan) begin
            acc_d = '1;
          end else begin
            acc_d                         = '0;
            acc_d[FRAC_W]                 = fields.hidden;
            acc_d[FRAC_W-1 -: FP_MAN_W]   = fields.mant;
          end
          state_d = (fields.n != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        acc_d   = dir_left_q ? (acc_q << 1) : (acc_q >> 1);
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done          = (state_q == DONE);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = done;
  // Result fields read as zero whenever no result is being presented.
  assign bus.int_out   = done ? acc_q[ACC_W-1:FRAC_W] : '0;
  assign bus.frac_out  = done ? acc_q[FRAC_W-1:0]     : '0;
  assign bus.sign_out  = done & sign_q;
  assign bus.zero_out  = done & zero_q;
  assign bus.inf_out   = done & inf_q;
  assign bus.nan_out   = done & nan_q;

endmodule

// File: tb/tb_fp16_to_fixed_seq.sv
// Self-checking bench: directed corner words, random words against an
// arithmetic reference, backpressure, busy-input and mid-shift reset.
module tb_fp16_to_fixed_seq;

  localparam int INT_W  = 16;
  localparam int FRAC_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp16_to_fixed_seq_if #(.INT_W(INT_W), .FRAC_W(FRAC_W)) bus ();

  fp16_to_fixed_seq #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Value = sig * 2^(eff-25); scaled by 2^FRAC_W (=2^32) gives sig << (eff+7).
  function automatic void ref_model(input logic [15:0] fp,
                                    output logic [15:0] e_int, output logic [31:0] e_frac,
                                    output logic [3:0] e_flags, output int e_lat);
    int e, m, eff;
    longint unsigned sig, scaled;
    e = int'(fp[14:10]);
    m = int'(fp[9:0]);
    e_flags = {fp[15], (e == 0 && m == 0), (e == 31 && m == 0), (e == 31 && m != 0)};
    if (e == 31) begin
      e_int  = 16'hFFFF;
      e_frac = 32'hFFFF_FFFF;
      e_lat  = 1;
    end else begin
      eff    = (e == 0) ? 1 : e;
      sig    = (e == 0) ? longint'(m) : longint'(1024 + m);
      scaled = sig << (eff + 7);
      e_int  = scaled[47:32];
      e_frac = scaled[31:0];
      e_lat  = (e == 0 && m == 0) ? 1 : 1 + ((eff > 15) ? eff - 15 : 15 - eff);
    end
  endfunction

  // Offers one word, then counts sampled cycles until out_valid (-1 on timeout).
  task automatic send(input logic [15:0] fp, output int lat);
    @(negedge clk);
    bus.fp_in     = fp;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.fp_in    = 16'($urandom);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fp_in     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.int_out !== '0 || bus.frac_out !== '0 ||
        {bus.sign_out, bus.zero_out, bus.inf_out, bus.nan_out} !== 4'b0) begin
      errors++;
      $display("FAIL reset_data int=%h frac=%h flags=%b required zeros", bus.int_out, bus.frac_out,
               {bus.sign_out, bus.zero_out, bus.inf_out, bus.nan_out});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] vec [10] = '{16'h4380, 16'h3E00, 16'h7BFF, 16'h0001, 16'h7C00,
                              16'h7E00, 16'h8000, 16'hFC00, 16'h3C00, 16'h83FF};
    logic [15:0] e_int;
    logic [31:0] e_frac;
    logic [3:0]  e_flags, got_flags;
    int          e_lat, lat;
    foreach (vec[i]) begin
      ref_model(vec[i], e_int, e_frac, e_flags, e_lat);
      send(vec[i], lat);
      got_flags = {bus.sign_out, bus.zero_out, bus.inf_out, bus.nan_out};
      checks++;
      if (lat !== e_lat) begin
        errors++;
        $display("FAIL directed_latency fp=%h got %0d required %0d", vec[i], lat, e_lat);
      end
      checks++;
      if (bus.int_out !== e_int || bus.frac_out !== e_frac) begin
        errors++;
        $display("FAIL directed_value fp=%h got %h.%h required %h.%h", vec[i],
                 bus.int_out, bus.frac_out, e_int, e_frac);
      end
      checks++;
      if (got_flags !== e_flags || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL directed_flags fp=%h got flags %b in_ready %b required %b 0", vec[i],
                 got_flags, bus.in_ready, e_flags);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [15:0] fp, e_int;
    logic [31:0] e_frac;
    logic [3:0]  e_flags, got_flags;
    int          e_lat, lat;
    for (int k = 0; k < 150; k++) begin
      fp = 16'($urandom);
      ref_model(fp, e_int, e_frac, e_flags, e_lat);
      send(fp, lat);
      got_flags = {bus.sign_out, bus.zero_out, bus.inf_out, bus.nan_out};
      checks++;
      if (lat !== e_lat || bus.int_out !== e_int || bus.frac_out !== e_frac || got_flags !== e_flags) begin
        errors++;
        $display("FAIL random fp=%h got lat %0d %h.%h flags %b required lat %0d %h.%h flags %b",
                 fp, lat, bus.int_out, bus.frac_out, got_flags, e_lat, e_int, e_frac, e_flags);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(16'h4100, lat);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.int_out !== 16'd2 || bus.frac_out !== 32'h8000_0000) begin
        errors++;
        $display("FAIL backpressure cycle %0d got v=%b rdy=%b %h.%h required 1 0 0002.80000000",
                 c, bus.out_valid, bus.in_ready, bus.int_out, bus.frac_out);
      end
      @(negedge clk);
    end
    release_result();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release got v=%b rdy=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    bus.fp_in    = 16'h7BFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.fp_in = 16'h3C00;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!bus.out_valid && bus.in_ready !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL busy_in_ready cycle %0d got %b required 0", c, bus.in_ready);
      end
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (lat !== 16 || bus.int_out !== 16'hFFE0 || bus.frac_out !== 32'h0) begin
      errors++;
      $display("FAIL busy_result got lat %0d %h.%h required 16 ffe0.00000000", lat, bus.int_out, bus.frac_out);
    end
    release_result();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_queue got out_valid %b required 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    bus.fp_in    = 16'h7BFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_busy got rdy=%b v=%b required 0 0", bus.in_ready, bus.out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.int_out !== '0 || bus.frac_out !== '0) begin
      errors++;
      $display("FAIL midreset_abort got rdy=%b v=%b %h.%h required 1 0 zeros",
               bus.in_ready, bus.out_valid, bus.int_out, bus.frac_out);
    end
    rst = 1'b0;
    send(16'h3C00, lat);
    checks++;
    if (lat !== 1 || bus.int_out !== 16'd1 || bus.frac_out !== 32'h0) begin
      errors++;
      $display("FAIL midreset_next got lat %0d %h.%h required 1 0001.00000000", lat, bus.int_out, bus.frac_out);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
